ex_div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage directly downstream of the ALU operand-B selection. Its A operand comes from the forwarded rs1 path and its B operand from the same selected operand the ALU receives (register value for R-type M ops). It produces one quotient or remainder per launch after a multi-cycle restoring-division sequence. The hazard unit holds the pipeline meanwhile.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/div_step.sv | 21 ++
 rtl/ex_div_unit.sv | 117 +++++++++++
 tb/tb_ex_div_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the EX-stage M-extension divider.
package riscv_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, pulling in the next dividend bit.
module div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic        i_bit,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);
  logic [32:0] w_sh;
  logic [31:0] w_diff;
  logic        w_ge;

  // 33-bit accumulator so the compare never overflows; the difference itself fits in 32 bits
  assign w_sh   = {i_rem, i_bit};
  assign w_ge   = (w_sh >= {1'b0, i_dvs});
  assign w_diff = w_sh[31:0] - i_dvs;
  assign o_rem  = w_ge ? w_diff : w_sh[31:0];
  assign o_quo  = {i_quo[30:0], w_ge};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative 32-bit RV32M divider: magnitude restoring division plus sign fix-up on exit.
module ex_div_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  logic [1:0]  r_state, r_op;
  logic        r_sa, r_sb, r_busy, r_done;
  logic [31:0] r_dvd, r_dvs, r_rem, r_quo, r_result;
  logic [4:0]  r_cnt;

  logic        w_sgn, w_dz, w_ov, w_r_sgn;
  logic [31:0] w_a_mag, w_b_mag, w_rem_nx, w_quo_nx, w_quo_fin, w_rem_fin;

  assign w_sgn   = ~op[0];
  assign w_a_mag = (w_sgn & A[31]) ? neg32(A) : A;
  assign w_b_mag = (w_sgn & B[31]) ? neg32(B) : B;
  assign w_dz    = (B == 32'd0);
  assign w_ov    = w_sgn & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);

  div_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_bit (r_dvd[31]),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  assign w_r_sgn   = ~r_op[0];
  assign w_quo_fin = (w_r_sgn & (r_sa ^ r_sb)) ? neg32(w_quo_nx) : w_quo_nx;
  assign w_rem_fin = (w_r_sgn & r_sa) ? neg32(w_rem_nx) : w_rem_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= DIV_IDLE;
      r_op     <= DIV_OP_DIV;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= DIV_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 5'd0;
      end else begin
        case (r_state)
          DIV_IDLE: if (start) begin
            r_op   <= op;
            r_sa   <= A[31];
            r_sb   <= B[31];
            r_dvd  <= w_a_mag;
            r_dvs  <= w_b_mag;
            r_rem  <= 32'd0;
            r_quo  <= 32'd0;
            r_cnt  <= 5'd0;
            r_busy <= 1'b1;
            // Special cases finish at once with the architecturally defined results
            if (w_dz) begin
              r_state  <= DIV_DONE;
              r_done   <= 1'b1;
              r_result <= op[1] ? A : 32'hFFFF_FFFF;
            end else if (w_ov) begin
              r_state  <= DIV_DONE;
              r_done   <= 1'b1;
              r_result <= op[1] ? 32'd0 : 32'h8000_0000;
            end else begin
              r_state <= DIV_CALC;
            end
          end
          DIV_CALC: begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state  <= DIV_DONE;
              r_done   <= 1'b1;
              r_cnt    <= 5'd0;
              r_result <= r_op[1] ? w_rem_fin : w_quo_fin;
            end
          end
          DIV_DONE: begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: vector table plus flush/reset/ignored-start sequences.
module tb_ex_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0, bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = 32'd0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[16];

  ex_div_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; start is sampled at the next edge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    start = 1'b1; op = o; A = a; B = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // n0 = edges already elapsed since (and including) E0.
  task automatic wait_done(input int n0, input int exp_lat, input string name);
    int n;
    logic [31:0] e;
    n = n0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: no done after %0d edges, expected %0d", name, n, exp_lat);
    end else begin
      check({name, " latency"}, 32'(n), 32'(exp_lat));
      check({name, " busy@done"}, 32'(busy), 32'd1);
      check({name, " result"}, result, e);
      last_exp = e;
      @(posedge clk); #1;
      check({name, " done pulse"}, 32'(done), 32'd0);
      check({name, " idle busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[4]  = '{DIV_OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{DIV_OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  1};
    vecs[6]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{DIV_OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33};
    vecs[9]  = '{DIV_OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          33};
    vecs[10] = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
    vecs[11] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
    vecs[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[14] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[15] = '{DIV_OP_REMU, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  1};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      if (vecs[i].lat > 1) check($sformatf("vec%0d busy@E0", i), 32'(busy), 32'd1);
      wait_done(1, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // start during CALC ignored, then immediate back-to-back launch
    launch(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; op = DIV_OP_REMU; A = 32'd50; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(7, 33, "ignored start");
    launch(DIV_OP_DIVU, 32'd50, 32'd5, 32'd10);
    wait_done(1, 33, "back-to-back");

    // flush at counter==10: no done, result held
    start = 1'b1; op = DIV_OP_DIVU; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("flush no done", 32'(pulses), 32'd0);
    check("flush result held", result, last_exp);

    // flush dominates start in IDLE
    start = 1'b1; flush = 1'b1; op = DIV_OP_DIV; A = 32'd9; B = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush>start busy", 32'(busy), 32'd0);
    check("flush>start done", 32'(done), 32'd0);

    // async reset mid-CALC
    start = 1'b1; op = DIV_OP_DIVU; A = 32'd77; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", result, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    launch(DIV_OP_DIVU, 32'd77, 32'd7, 32'd11);
    wait_done(1, 33, "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
